// File: rtl/data_store_buf_if.sv
// MEM-stage request/response and data_ram port bundle for the posted-store buffer.
// slave is the buffer's view; master is the pipeline/RAM side.
interface data_store_buf_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_sel;
    logic [DW-1:0] mem_wdata;
    logic          sync;
    logic [DW-1:0] mem_rdata;
    logic          stall_req;
    logic          empty;

    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [SW-1:0] ram_sel;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, sync, ram_rdata,
        output mem_rdata, stall_req, empty, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );

    modport master (
        output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, sync, ram_rdata,
        input  mem_rdata, stall_req, empty, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
    );
endinterface

// File: rtl/data_store_buf.sv
// Posted-store buffer between MEM and data_ram: loads go straight to the RAM, stores drain on idle cycles.
// Define STORE_FWD_EN to forward buffered store bytes to loads instead of stalling on a word match.
module data_store_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    data_store_buf_if.slave  bus
);
    localparam int SW = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - 2;

    logic [WW-1:0]    addr_mem [DEPTH];
    logic [SW-1:0]    sel_mem  [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;

    logic [WW-1:0]    req_word;
    logic [DEPTH-1:0] hit;
    logic             any_hit;
    logic             q_empty;
    logic             q_full;
    logic             stall;
    logic             accept;
    logic             store_acc;
    logic             load_acc;
    logic             drain;
    logic [DW-1:0]    load_data;

    assign req_word = bus.mem_addr[AW-1:2];
    assign q_empty  = (count_reg == '0);
    assign q_full   = (count_reg == (PW+1)'(DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = valid_reg[gi] && (addr_mem[gi] == req_word);
        end
    endgenerate

    assign any_hit = |hit;

    always_comb begin
        stall = 1'b0;
        if (rst) begin
            if (bus.mem_ce && bus.mem_we && q_full)
                stall = 1'b1;
            if (bus.sync && !q_empty)
                stall = 1'b1;
`ifndef STORE_FWD_EN
            // Without forwarding, a load must wait until the overlapping stores have retired.
            if (bus.mem_ce && !bus.mem_we && any_hit)
                stall = 1'b1;
`endif
        end
    end

    assign accept    = rst && bus.mem_ce && !stall;
    assign store_acc = accept && bus.mem_we;
    assign load_acc  = accept && !bus.mem_we;
    // Requests never coincide with a drain, so push and pop are mutually exclusive.
    assign drain     = rst && !q_empty && !accept;

`ifdef STORE_FWD_EN
    // Walk entries oldest to youngest so the youngest matching byte wins.
    generate
        for (gi = 0; gi < SW; gi++) begin : g_lane
            logic [7:0]    lane;
            logic [PW-1:0] idx;
            always_comb begin
                lane = bus.ram_rdata[gi*8 +: 8];
                idx  = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    idx = rd_ptr_reg + PW'(k);
                    if (hit[idx] && sel_mem[idx][gi])
                        lane = data_mem[idx][gi*8 +: 8];
                end
            end
            assign load_data[gi*8 +: 8] = lane;
        end
    endgenerate
`else
    assign load_data = bus.ram_rdata;
`endif

    logic          ram_ce_c;
    logic          ram_we_c;
    logic [AW-1:0] ram_addr_c;
    logic [SW-1:0] ram_sel_c;
    logic [DW-1:0] ram_wdata_c;
    logic [DW-1:0] mem_rdata_c;

    always_comb begin
        ram_ce_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_addr_c  = '0;
        ram_sel_c   = '0;
        ram_wdata_c = '0;
        mem_rdata_c = '0;
        if (load_acc) begin
            ram_ce_c    = 1'b1;
            ram_addr_c  = bus.mem_addr;
            ram_sel_c   = bus.mem_sel;
            mem_rdata_c = load_data;
        end else if (drain) begin
            ram_ce_c    = 1'b1;
            ram_we_c    = 1'b1;
            ram_addr_c  = {addr_mem[rd_ptr_reg], 2'b00};
            ram_sel_c   = sel_mem[rd_ptr_reg];
            ram_wdata_c = data_mem[rd_ptr_reg];
        end
    end

    assign bus.ram_ce    = ram_ce_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_sel   = ram_sel_c;
    assign bus.ram_wdata = ram_wdata_c;
    assign bus.mem_rdata = mem_rdata_c;
    assign bus.stall_req = stall;
    assign bus.empty     = !rst || q_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else if (store_acc) begin
            valid_reg[wr_ptr_reg] <= 1'b1;
            wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            count_reg             <= count_reg + 1'b1;
        end else if (drain) begin
            valid_reg[rd_ptr_reg] <= 1'b0;
            rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            count_reg             <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (store_acc) begin
            addr_mem[wr_ptr_reg] <= req_word;
            sel_mem[wr_ptr_reg]  <= bus.mem_sel;
            data_mem[wr_ptr_reg] <= bus.mem_wdata;
        end
    end
endmodule
